// File: rtl/mem_access.sv
`default_nettype none
// mem_access: load/store stage that runs one execute op per handshake on a valid/ready
// memory bus, then sizes and extends load data for write_back. Rev 1.0
module mem_access #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic [5:0]  in_dest,
  input  logic [31:0] in_next_pc,
  input  logic [1:0]  in_mem_op,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [5:0]  dest,
  output logic [31:0] next_pc,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        mem_valid_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        out_valid_q;
  logic [31:0] result_q;
  logic [5:0]  dest_q;
  logic [31:0] next_pc_q;
  logic        misalign_q;

  // Op held across the bus transaction.
  logic        pend_load_q;
  logic        pend_unsigned_q;
  logic [1:0]  pend_size_q;
  logic [5:0]  pend_dest_q;
  logic [31:0] pend_next_pc_q;
  logic [31:0] pend_addr_q;

  logic        is_load;
  logic        is_store;
  logic        aligned;
  logic        accept;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] lane_data;
  logic [31:0] load_ext_d;

  assign in_ready = (state_q == S_IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    is_load  = (in_mem_op == 2'b01);
    is_store = (in_mem_op == 2'b10);
    case (in_size)
      2'b00: begin
        aligned = 1'b1;
        wstrb_d = 4'b0001 << in_result[1:0];
        wdata_d = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        aligned = ~in_result[0];
        wstrb_d = 4'b0011 << in_result[1:0];
        wdata_d = {2{in_store_data[15:0]}};
      end
      default: begin
        aligned = (in_result[1:0] == 2'b00);
        wstrb_d = 4'b1111;
        wdata_d = in_store_data;
      end
    endcase
    if (is_load) wstrb_d = 4'b0000;

    lane_data = mem_rdata >> {pend_addr_q[1:0], 3'b000};
    case (pend_size_q)
      2'b00:   load_ext_d = pend_unsigned_q ? {24'b0, lane_data[7:0]}
                                            : {{24{lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_ext_d = pend_unsigned_q ? {16'b0, lane_data[15:0]}
                                            : {{16{lane_data[15]}}, lane_data[15:0]};
      default: load_ext_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      mem_valid_q     <= 1'b0;
      mem_addr_q      <= 32'b0;
      mem_wdata_q     <= 32'b0;
      mem_wstrb_q     <= 4'b0;
      out_valid_q     <= 1'b0;
      result_q        <= 32'b0;
      dest_q          <= 6'b0;
      next_pc_q       <= RESET_PC;
      misalign_q      <= 1'b0;
      pend_load_q     <= 1'b0;
      pend_unsigned_q <= 1'b0;
      pend_size_q     <= 2'b0;
      pend_dest_q     <= 6'b0;
      pend_next_pc_q  <= 32'b0;
      pend_addr_q     <= 32'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if ((is_load || is_store) && aligned) begin
              mem_valid_q     <= 1'b1;
              mem_addr_q      <= {in_result[31:2], 2'b00};
              mem_wdata_q     <= wdata_d;
              mem_wstrb_q     <= wstrb_d;
              pend_load_q     <= is_load;
              pend_unsigned_q <= in_unsigned;
              pend_size_q     <= in_size;
              pend_dest_q     <= in_dest;
              pend_next_pc_q  <= in_next_pc;
              pend_addr_q     <= in_result;
              state_q         <= S_BUS;
            end else begin
              // Non-memory op, or a misaligned access reported without touching the bus.
              out_valid_q <= 1'b1;
              result_q    <= in_result;
              next_pc_q   <= in_next_pc;
              misalign_q  <= is_load || is_store;
              dest_q      <= (is_load || is_store) ? 6'b0 : in_dest;
            end
          end
        end
        S_BUS: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            out_valid_q <= 1'b1;
            misalign_q  <= 1'b0;
            result_q    <= pend_load_q ? load_ext_d : pend_addr_q;
            dest_q      <= pend_load_q ? pend_dest_q : 6'b0;
            next_pc_q   <= pend_next_pc_q;
            state_q     <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign dest      = dest_q;
  assign next_pc   = next_pc_q;
  assign misalign  = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// tb_mem_access: directed vectors with hand-computed expectations for mem_access.
// Rev 1.0
module tb_mem_access;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [31:0] in_store_data = '0;
  logic [5:0]  in_dest = '0;
  logic [31:0] in_next_pc = '0;
  logic [1:0]  in_mem_op = '0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic [31:0] result;
  logic [5:0]  dest;
  logic [31:0] next_pc;
  logic        misalign;

  int n_chk  = 0;
  int n_pass = 0;

  mem_access #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_store_data(in_store_data), .in_dest(in_dest),
    .in_next_pc(in_next_pc), .in_mem_op(in_mem_op), .in_size(in_size),
    .in_unsigned(in_unsigned),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .result(result), .dest(dest), .next_pc(next_pc),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [5:0] d, input logic [31:0] npc);
    in_valid      = 1'b1;
    in_mem_op     = op;
    in_size       = sz;
    in_unsigned   = uns;
    in_result     = addr;
    in_store_data = sdata;
    in_dest       = d;
    in_next_pc    = npc;
  endtask

  // Full aligned bus transaction with `waits` cycles of mem_ready low.
  task automatic mem_txn(input string tag, input logic [1:0] op, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [5:0] d, input logic [31:0] npc, input int waits,
                         input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input logic [31:0] e_res, input logic [5:0] e_dest);
    drive(op, sz, uns, addr, sdata, d, npc);
    step();
    in_valid = 1'b0;
    chk({tag, "_mvalid"}, {31'b0, mem_valid}, 32'd1);
    chk({tag, "_addr"}, mem_addr, e_addr);
    chk({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, e_strb});
    if (op == 2'b10) chk({tag, "_wdata"}, mem_wdata, e_wdata);
    chk({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, "_hold"}, {31'b0, mem_valid}, 32'd1);
      chk({tag, "_hold_addr"}, mem_addr, e_addr);
      chk({tag, "_no_out"}, {31'b0, out_valid}, 32'd0);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ready = 1'b0;
    chk({tag, "_ovalid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_result"}, result, e_res);
    chk({tag, "_dest"}, {26'b0, dest}, {26'b0, e_dest});
    chk({tag, "_npc"}, next_pc, npc);
    chk({tag, "_mis"}, {31'b0, misalign}, 32'd0);
    chk({tag, "_mdrop"}, {31'b0, mem_valid}, 32'd0);
    chk({tag, "_done_busy"}, {31'b0, in_ready}, 32'd0);
    step();
    chk({tag, "_pulse"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_hold_res"}, result, e_res);
    chk({tag, "_idle_rdy"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mvalid", {31'b0, mem_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dest", {26'b0, dest}, 32'd0);
    chk("rst_npc", next_pc, RST_PC);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ready", {31'b0, in_ready}, 32'd1);

    // Single ALU op.
    drive(2'b00, 2'b10, 1'b0, 32'h1234, 32'h0, 6'd5, 32'h104);
    step();
    in_valid = 1'b0;
    chk("alu_ovalid", {31'b0, out_valid}, 32'd1);
    chk("alu_result", result, 32'h1234);
    chk("alu_dest", {26'b0, dest}, 32'd5);
    chk("alu_npc", next_pc, 32'h104);
    chk("alu_nomem", {31'b0, mem_valid}, 32'd0);
    step();
    chk("alu_pulse", {31'b0, out_valid}, 32'd0);

    // Three back-to-back ALU ops, one pulse per cycle.
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 2'b00, 1'b0, 32'hA000 + i, 32'h0, 6'(10 + i), 32'h200 + 4 * i);
      step();
      chk("b2b_ovalid", {31'b0, out_valid}, 32'd1);
      chk("b2b_result", result, 32'hA000 + i);
      chk("b2b_dest", {26'b0, dest}, 32'(10 + i));
      chk("b2b_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_end", {31'b0, out_valid}, 32'd0);

    mem_txn("lb", 2'b01, 2'b00, 1'b0, 32'h1003, 32'h0, 6'd7, 32'h300, 3,
            32'h8012_3456, 32'h1000, 4'b0000, 32'h0, 32'hFFFF_FF80, 6'd7);
    mem_txn("lbu", 2'b01, 2'b00, 1'b1, 32'h1003, 32'h0, 6'd8, 32'h304, 3,
            32'h8012_3456, 32'h1000, 4'b0000, 32'h0, 32'h0000_0080, 6'd8);
    mem_txn("lh", 2'b01, 2'b01, 1'b0, 32'h2002, 32'h0, 6'd9, 32'h308, 0,
            32'h8001_7F7F, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_8001, 6'd9);
    mem_txn("lhu", 2'b01, 2'b01, 1'b1, 32'h2000, 32'h0, 6'd9, 32'h30C, 1,
            32'h1234_F00D, 32'h2000, 4'b0000, 32'h0, 32'h0000_F00D, 6'd9);
    mem_txn("lw", 2'b01, 2'b11, 1'b0, 32'h0000_0004, 32'h0, 6'd3, 32'h310, 1,
            32'h1234_5678, 32'h4, 4'b0000, 32'h0, 32'h1234_5678, 6'd3);
    mem_txn("sh", 2'b10, 2'b01, 1'b0, 32'h2002, 32'h0000_ABCD, 6'd4, 32'h314, 2,
            32'h0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h2002, 6'd0);
    mem_txn("sb", 2'b10, 2'b00, 1'b0, 32'h1001, 32'hFFFF_FF5A, 6'd4, 32'h318, 0,
            32'h0, 32'h1000, 4'b0010, 32'h5A5A_5A5A, 32'h1001, 6'd0);
    mem_txn("sw", 2'b10, 2'b10, 1'b0, 32'h5008, 32'hCAFE_BABE, 6'd4, 32'h31C, 1,
            32'h0, 32'h5008, 4'b1111, 32'hCAFE_BABE, 32'h5008, 6'd0);

    // Misaligned word load: fault reported without a bus request.
    drive(2'b01, 2'b10, 1'b0, 32'h3001, 32'h0, 6'd12, 32'h400);
    step();
    in_valid = 1'b0;
    chk("mis_ovalid", {31'b0, out_valid}, 32'd1);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_dest", {26'b0, dest}, 32'd0);
    chk("mis_result", result, 32'h3001);
    chk("mis_nomem", {31'b0, mem_valid}, 32'd0);

    // Misaligned half store, then an op code 11 that behaves as ALU and clears misalign.
    drive(2'b10, 2'b01, 1'b0, 32'h3003, 32'h0, 6'd13, 32'h404);
    step();
    chk("mish_flag", {31'b0, misalign}, 32'd1);
    chk("mish_nomem", {31'b0, mem_valid}, 32'd0);
    drive(2'b11, 2'b10, 1'b0, 32'h3001, 32'h0, 6'd14, 32'h408);
    step();
    in_valid = 1'b0;
    chk("op3_ovalid", {31'b0, out_valid}, 32'd1);
    chk("op3_dest", {26'b0, dest}, 32'd14);
    chk("op3_mis_clr", {31'b0, misalign}, 32'd0);
    chk("op3_nomem", {31'b0, mem_valid}, 32'd0);

    // Reset while the bus request is outstanding.
    drive(2'b01, 2'b10, 1'b0, 32'h4000, 32'h0, 6'd15, 32'h500);
    step();
    in_valid = 1'b0;
    chk("rbus_mvalid", {31'b0, mem_valid}, 32'd1);
    reset = 1'b1;
    step();
    chk("rbus_mdrop", {31'b0, mem_valid}, 32'd0);
    chk("rbus_noout", {31'b0, out_valid}, 32'd0);
    chk("rbus_npc", next_pc, RST_PC);
    chk("rbus_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("rbus_after", {31'b0, out_valid}, 32'd0);
    chk("rbus_after_mv", {31'b0, mem_valid}, 32'd0);
    chk("rbus_idle", {31'b0, in_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
